// File: rtl/itype_detector_mret.sv
// Multi-retire itype classifier for the trace connector.
// Classifies up to NRET committed instructions per cycle into itype codes. The
// classified bundles are buffered in a small FIFO toward the packet encoder.
// Bundles that arrive while the FIFO is full are counted in a saturating
// drop counter.

package connector_pkg;
  typedef enum logic [7:0] {
    ADD   = 8'd0,
    SUB   = 8'd1,
    LOAD  = 8'd2,
    STORE = 8'd3,
    EQ    = 8'd4,
    NE    = 8'd5,
    LTS   = 8'd6,
    GES   = 8'd7,
    LTU   = 8'd8,
    GEU   = 8'd9,
    JAL   = 8'd10,
    JALR  = 8'd11,
    MRET  = 8'd12,
    SRET  = 8'd13,
    DRET  = 8'd14
  } fu_op;
endpackage

module itype_detector_mret #(
  parameter int NRET      = 2,
  parameter int ITYPE_LEN = 3,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NRET-1:0]                    valid_i,
  input  connector_pkg::fu_op [NRET-1:0]     op_i,
  input  logic [NRET-1:0]                    branch_taken_i,
  input  logic [NRET-1:0][4:0]               rd_i,
  input  logic [NRET-1:0][4:0]               rs1_i,
  input  logic                               exception_i,
  input  logic                               interrupt_i,
  output logic                               ready_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [NRET-1:0][ITYPE_LEN-1:0]     itype_o,
  output logic [NRET-1:0]                    lane_valid_o,
  output logic [CNT_W-1:0]                   drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [NRET-1:0][ITYPE_LEN-1:0] itype_c;
  logic [NRET-1:0]                mask_c;
  logic [3:0]                     code;
  logic                           event_c;

  logic [NRET-1:0][ITYPE_LEN-1:0] mem_itype [DEPTH];
  logic [NRET-1:0]                mem_mask  [DEPTH];
  logic [AW-1:0]                  wr_ptr;
  logic [AW-1:0]                  rd_ptr;
  logic [AW:0]                    count;
  logic                           full;
  logic                           push_req;
  logic                           push;
  logic                           pop;
  logic                           drop;

  // x1 (ra) and x5 (t0) are the link registers for call/return inference.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [3:0] classify(
    input logic               first_lane,
    input logic               valid,
    input connector_pkg::fu_op op,
    input logic               taken,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic               exc,
    input logic               irq
  );
    if (first_lane && exc) return 4'd1;
    if (first_lane && irq) return 4'd2;
    if (!valid)            return 4'd0;
    case (op)
      connector_pkg::MRET, connector_pkg::SRET, connector_pkg::DRET:
        return 4'd3;
      connector_pkg::EQ, connector_pkg::NE, connector_pkg::LTS,
      connector_pkg::GES, connector_pkg::LTU, connector_pkg::GEU:
        return taken ? 4'd5 : 4'd4;
      connector_pkg::JALR: begin
        if (ITYPE_LEN == 3)                                return 4'd6;
        if (is_link(rd) && is_link(rs1) && (rd != rs1))    return 4'd10;
        if (is_link(rd))                                   return 4'd6;
        if (is_link(rs1))                                  return 4'd11;
        return 4'd8;
      end
      default: return 4'd0;
    endcase
  endfunction

  // Per-lane classification; a trap owns the bundle, so upper lanes are squashed.
  always_comb begin
    itype_c = '0;
    mask_c  = '0;
    code    = '0;
    event_c = exception_i | interrupt_i;
    for (int l = 0; l < NRET; l++) begin
      code = classify(l == 0, valid_i[l], op_i[l], branch_taken_i[l],
                      rd_i[l], rs1_i[l], exception_i, interrupt_i);
      if (l == 0) begin
        itype_c[l] = code[ITYPE_LEN-1:0];
        mask_c[l]  = valid_i[l] | event_c;
      end else if (!event_c) begin
        itype_c[l] = code[ITYPE_LEN-1:0];
        mask_c[l]  = valid_i[l];
      end
    end
  end

  assign full     = (count == FULL_CNT);
  assign push_req = |mask_c;
  assign push     = push_req & ~full;
  assign drop     = push_req & full;
  assign pop      = valid_o & ready_i;

  assign ready_o      = ~full;
  assign valid_o      = (count != '0);
  assign itype_o      = valid_o ? mem_itype[rd_ptr] : '0;
  assign lane_valid_o = valid_o ? mem_mask[rd_ptr]  : '0;

  // FIFO storage, pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push) begin
        mem_itype[wr_ptr] <= itype_c;
        mem_mask[wr_ptr]  <= mask_c;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_itype_detector_mret.sv
// Directed bench for itype_detector_mret: three instances share stimulus
// (3-bit itypes, 4-bit itypes, and a 2-bit drop counter).

module tb_itype_detector_mret;
  import connector_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       valid;
  fu_op [1:0]       op;
  logic [1:0]       taken;
  logic [1:0][4:0]  rd;
  logic [1:0][4:0]  rs1;
  logic             exc;
  logic             irq;
  logic             rdy_in;

  logic             ready_a, valid_a;
  logic [1:0][2:0]  itype_a;
  logic [1:0]       mask_a;
  logic [7:0]       drop_a;

  logic             ready_b, valid_b;
  logic [1:0][3:0]  itype_b;
  logic [1:0]       mask_b;
  logic [7:0]       drop_b;

  logic             ready_c, valid_c;
  logic [1:0][2:0]  itype_c;
  logic [1:0]       mask_c;
  logic [1:0]       drop_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  itype_detector_mret #(.NRET(2), .ITYPE_LEN(3), .DEPTH(4), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .branch_taken_i(taken),
    .rd_i(rd), .rs1_i(rs1), .exception_i(exc), .interrupt_i(irq),
    .ready_o(ready_a), .valid_o(valid_a), .ready_i(rdy_in),
    .itype_o(itype_a), .lane_valid_o(mask_a), .drop_cnt_o(drop_a));

  itype_detector_mret #(.NRET(2), .ITYPE_LEN(4), .DEPTH(4), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .branch_taken_i(taken),
    .rd_i(rd), .rs1_i(rs1), .exception_i(exc), .interrupt_i(irq),
    .ready_o(ready_b), .valid_o(valid_b), .ready_i(rdy_in),
    .itype_o(itype_b), .lane_valid_o(mask_b), .drop_cnt_o(drop_b));

  itype_detector_mret #(.NRET(2), .ITYPE_LEN(3), .DEPTH(4), .CNT_W(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .branch_taken_i(taken),
    .rd_i(rd), .rs1_i(rs1), .exception_i(exc), .interrupt_i(irq),
    .ready_o(ready_c), .valid_o(valid_c), .ready_i(rdy_in),
    .itype_o(itype_c), .lane_valid_o(mask_c), .drop_cnt_o(drop_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 2'b00; op = {ADD, ADD}; taken = 2'b00;
    rd = '0; rs1 = '0; exc = 1'b0; irq = 1'b0;
  endtask

  // lane 0 only; 3-bit instance always reports 6, 4-bit instance gets exp4
  task automatic jalr_case(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [3:0] exp4,
                           input string tag);
    valid = 2'b01; op = {ADD, JALR}; rd = {5'd0, r_d}; rs1 = {5'd0, r_s1};
    step();
    idle_inputs();
    check({tag, "_b"}, 32'(itype_b), {28'd0, exp4});
    check({tag, "_a"}, 32'(itype_a), 32'h6);
    step();
  endtask

  task automatic push_lane0(input fu_op o, input logic t);
    valid = 2'b01; op = {ADD, o}; taken = {1'b0, t};
    step();
  endtask

  initial begin
    rst = 1'b1; rdy_in = 1'b0;
    idle_inputs();
    step(); step();
    check("rst_valid",  32'(valid_a), 32'd0);
    check("rst_ready",  32'(ready_a), 32'd1);
    check("rst_drop",   32'(drop_a),  32'd0);
    check("rst_itype",  32'(itype_a), 32'd0);
    check("rst_mask",   32'(mask_a),  32'd0);
    rst = 1'b0;
    step();

    // two branches, pushed into an empty FIFO with ready_i high
    rdy_in = 1'b1;
    valid = 2'b11; op = {NE, EQ}; taken = 2'b01;
    #1;
    check("t1_no_fallthru", 32'(valid_a), 32'd0);
    step();
    idle_inputs();
    check("t1_valid",   32'(valid_a), 32'd1);
    check("t1_itype_a", 32'(itype_a), {26'd0, 3'd4, 3'd5});
    check("t1_itype_b", 32'(itype_b), {24'd0, 4'd4, 4'd5});
    check("t1_mask",    32'(mask_a),  32'b11);
    step();
    check("t1_popped",  32'(valid_a), 32'd0);

    // exception squashes lane 1
    exc = 1'b1; valid = 2'b11; op = {MRET, JALR};
    step();
    idle_inputs();
    check("t2_itype", 32'(itype_a), {26'd0, 3'd0, 3'd1});
    check("t2_mask",  32'(mask_a),  32'b01);
    step();
    // interrupt with no commit
    irq = 1'b1; valid = 2'b10; op = {EQ, ADD};
    step();
    idle_inputs();
    check("t2_irq_itype", 32'(itype_a), {26'd0, 3'd0, 3'd2});
    check("t2_irq_mask",  32'(mask_a),  32'b01);
    step();
    check("t2_empty", 32'(valid_a), 32'd0);

    // JALR link-register inference
    jalr_case(5'd1, 5'd5, 4'd10, "t3_swap");
    jalr_case(5'd1, 5'd1, 4'd6,  "t3_call");
    jalr_case(5'd0, 5'd1, 4'd11, "t3_ret");
    jalr_case(5'd0, 5'd7, 4'd8,  "t3_jump");

    // fill with ready_i low, then overflow twice
    rdy_in = 1'b0;
    push_lane0(EQ, 1'b0);
    push_lane0(EQ, 1'b1);
    valid = 2'b11; op = {EQ, MRET}; taken = 2'b10;
    step();
    push_lane0(JALR, 1'b0);
    check("t4_full_ready", 32'(ready_a), 32'd0);
    check("t4_head_hold",  32'(itype_a), {26'd0, 3'd0, 3'd4});
    push_lane0(EQ, 1'b0);
    push_lane0(MRET, 1'b0);
    idle_inputs();
    check("t4_drop_a", 32'(drop_a), 32'd2);
    check("t4_drop_c", 32'(drop_c), 32'd2);
    check("t4_head_hold2", 32'(itype_a), {26'd0, 3'd0, 3'd4});
    rdy_in = 1'b1;
    check("t4_d0", 32'({mask_a, itype_a}), {24'd0, 2'b01, 3'd0, 3'd4});
    step();
    check("t4_d1", 32'({mask_a, itype_a}), {24'd0, 2'b01, 3'd0, 3'd5});
    step();
    check("t4_d2", 32'({mask_a, itype_a}), {24'd0, 2'b11, 3'd5, 3'd3});
    step();
    check("t4_d3", 32'({mask_a, itype_a}), {24'd0, 2'b01, 3'd0, 3'd6});
    step();
    check("t4_drained", 32'(valid_a), 32'd0);

    // saturation of the 2-bit drop counter
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) push_lane0(ADD, 1'b0);
    push_lane0(ADD, 1'b0);
    check("t5_drop_c_3", 32'(drop_c), 32'd3);
    for (int i = 0; i < 4; i++) push_lane0(ADD, 1'b0);
    check("t5_drop_c_sat", 32'(drop_c), 32'd3);
    check("t5_drop_a",     32'(drop_a), 32'd7);

    // full with pop and push attempt: push dropped, pop proceeds
    rdy_in = 1'b1;
    push_lane0(EQ, 1'b1);
    idle_inputs();
    rdy_in = 1'b0;
    check("t5_fullpop_drop",  32'(drop_a),  32'd8);
    check("t5_fullpop_ready", 32'(ready_a), 32'd1);
    check("t5_fullpop_valid", 32'(valid_a), 32'd1);

    // reset with 3 entries stored; inputs during reset are ignored
    rst = 1'b1; valid = 2'b11; op = {EQ, EQ};
    step();
    rst = 1'b0;
    idle_inputs();
    check("t6_valid", 32'(valid_a), 32'd0);
    check("t6_ready", 32'(ready_a), 32'd1);
    check("t6_drop",  32'(drop_a),  32'd0);
    check("t6_drop_c", 32'(drop_c), 32'd0);
    check("t6_itype", 32'(itype_a), 32'd0);
    check("t6_mask",  32'(mask_a),  32'd0);
    step();
    check("t6_still_empty", 32'(valid_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
